// File: rtl/divider_pkg.sv
// Shared definitions for the fixed-point divider: FSM state encoding and
// the saturation-pattern helper used for clamping and overflow limits.
// No ports; imported by divider and div_step.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest quotient the helper can describe.
  localparam int SAT_W = 128;

  // Bit pattern of the most positive (neg=0) or most negative (neg=1)
  // value of a 'width'-bit signed number. Read as unsigned, the same
  // patterns are the largest quotient magnitudes that fit without clamping.
  function automatic logic [SAT_W-1:0] sat_pattern(input int width, input logic neg);
    logic [SAT_W-1:0] msb;
    msb = SAT_W'(1) << (width - 1);
    return neg ? msb : (msb - SAT_W'(1));
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift next dividend bit into the partial
// remainder, subtract the divisor when it fits. Purely combinational.
// Ports: rem_i/rem_o partial remainder in/out, bit_i next dividend bit,
//        dvs_i divisor magnitude, q_o resulting quotient bit.
module div_step
  import divider_pkg::*;
#(
  parameter int B_WIDTH = 16
) (
  input  logic [B_WIDTH:0]   rem_i,
  input  logic               bit_i,
  input  logic [B_WIDTH-1:0] dvs_i,
  output logic [B_WIDTH:0]   rem_o,
  output logic               q_o
);

  // One extra bit so the shifted remainder can never wrap.
  logic [B_WIDTH+1:0] shifted;
  logic [B_WIDTH:0]   diff;
  logic               fits;

  always_comb begin
    shifted = {rem_i, bit_i};
    fits    = shifted >= (B_WIDTH+2)'(dvs_i);
    // When the divisor fits the difference is below the divisor, so the
    // top shifted bit is not needed to form it.
    diff    = shifted[B_WIDTH:0] - {1'b0, dvs_i};
    rem_o   = fits ? diff : shifted[B_WIDTH:0];
    q_o     = fits;
  end

endmodule

// File: rtl/divider.sv
// Signed fixed-point divider: out = (a <<< IN_SCALE) / b, truncated toward zero.
// Latency: out_valid pulses DIV_BITS+1 cycles after the accepting edge.
// Backpressure: ready is high only when idle; start while busy is dropped.
// Ports: clk, rst (sync, active high), start/a/b request, ready,
//        out_valid pulse, out quotient, div_by_zero and overflow flags.
module divider
  import divider_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int IN_SCALE  = 16,
  parameter int OUT_WIDTH = A_WIDTH + IN_SCALE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  output logic                 ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int DIV_BITS = A_WIDTH + IN_SCALE;
  localparam int CNT_W    = $clog2(DIV_BITS + 1);
  // Comparison width covers both the raw quotient and the output range.
  localparam int CMP_W    = ((DIV_BITS > OUT_WIDTH) ? DIV_BITS : OUT_WIDTH) + 1;

  localparam logic [CMP_W-1:0]     POS_LIM  = CMP_W'(sat_pattern(OUT_WIDTH, 1'b0));
  localparam logic [CMP_W-1:0]     NEG_LIM  = CMP_W'(sat_pattern(OUT_WIDTH, 1'b1));
  localparam logic [OUT_WIDTH-1:0] OUT_MAX  = OUT_WIDTH'(sat_pattern(OUT_WIDTH, 1'b0));
  localparam logic [OUT_WIDTH-1:0] OUT_MIN  = OUT_WIDTH'(sat_pattern(OUT_WIDTH, 1'b1));
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(DIV_BITS);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  // Holds the scaled dividend magnitude; quotient bits shift in at the LSB
  // as dividend bits leave at the MSB.
  logic [DIV_BITS-1:0]    quo_q, quo_d;
  logic [B_WIDTH:0]       rem_q, rem_d;
  logic [B_WIDTH-1:0]     dvs_q, dvs_d;
  logic                   sign_q, sign_d;
  logic                   a_neg_q, a_neg_d;
  logic                   bz_q, bz_d;
  logic [OUT_WIDTH-1:0]   out_q, out_d;
  logic                   dbz_q, dbz_d;
  logic                   ovf_q, ovf_d;

  logic [A_WIDTH-1:0]     a_mag;
  logic [B_WIDTH-1:0]     b_mag;
  logic [DIV_BITS-1:0]    dvd_init;
  logic [B_WIDTH:0]       step_rem;
  logic                   step_q;
  logic [CMP_W-1:0]       q_ext;
  logic [OUT_WIDTH-1:0]   res_val;
  logic                   res_ovf;

  div_step #(
    .B_WIDTH (B_WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[DIV_BITS-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // Magnitudes as unsigned values; the most negative input maps to
  // 2^(W-1), which still fits the unsigned field.
  always_comb begin
    a_mag    = a[A_WIDTH-1] ? (~a + A_WIDTH'(1)) : a;
    b_mag    = b[B_WIDTH-1] ? (~b + B_WIDTH'(1)) : b;
    dvd_init = DIV_BITS'(a_mag) << IN_SCALE;
  end

  // Sign correction and clamping of the finished unsigned quotient.
  // A negative result may reach one step further than a positive one.
  always_comb begin
    q_ext   = CMP_W'(quo_q);
    res_val = '0;
    res_ovf = 1'b0;
    if (bz_q) begin
      res_val = a_neg_q ? OUT_MIN : OUT_MAX;
    end else if (!sign_q) begin
      if (q_ext > POS_LIM) begin
        res_val = OUT_MAX;
        res_ovf = 1'b1;
      end else begin
        res_val = q_ext[OUT_WIDTH-1:0];
      end
    end else begin
      if (q_ext > NEG_LIM) begin
        res_val = OUT_MIN;
        res_ovf = 1'b1;
      end else begin
        res_val = ~q_ext[OUT_WIDTH-1:0] + OUT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sign_d  = sign_q;
    a_neg_d = a_neg_q;
    bz_d    = bz_q;
    out_d   = out_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          quo_d   = dvd_init;
          rem_d   = '0;
          dvs_d   = b_mag;
          sign_d  = a[A_WIDTH-1] ^ b[B_WIDTH-1];
          a_neg_d = a[A_WIDTH-1];
          bz_d    = (b == '0);
        end
      end
      CALC: begin
        // DIV_BITS step cycles, then one cycle to publish the result.
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          out_d   = res_val;
          dbz_d   = bz_q;
          ovf_d   = res_ovf;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          quo_d = {quo_q[DIV_BITS-2:0], step_q};
          rem_d = step_rem;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      bz_q    <= 1'b0;
      out_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sign_q  <= sign_d;
      a_neg_q <= a_neg_d;
      bz_q    <= bz_d;
      out_q   <= out_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out         = out_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
